// File: rtl/gpio_cmd_decoder_pkg.sv
// -----------------------------------------------------------------------------
// gpio_cmd_decoder_pkg
// Shared definitions for the GPIO command decoder and the host-side code that
// drives it: width defaults, opcode values, state codes, command-word layout
// and status-word bit positions.
// -----------------------------------------------------------------------------
package gpio_cmd_decoder_pkg;

  // Width defaults
  localparam int NB_GPIO_DEF   = 32;
  localparam int NB_DATA_DEF   = 8;
  localparam int N_PIX_DEF     = 3;
  localparam int NB_IMAGE_DEF  = 10;
  localparam int NB_OPCODE_DEF = 3;

  // Host command opcodes, carried in the top NB_OPCODE bits of the command word
  typedef enum logic [2:0] {
    OP_NOP        = 3'b000,
    OP_SOFT_RST   = 3'b001,
    OP_SET_LEN    = 3'b010,
    OP_LOAD_START = 3'b011,
    OP_DATA       = 3'b100,
    OP_START_PROC = 3'b101,
    OP_READ_START = 3'b110,
    OP_READ_NEXT  = 3'b111
  } opcode_e;

  // Decoder states; the code is reported in the status word
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PROC  = 3'd2,
    ST_READ  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  // Command-word layout
  localparam int CMD_TOGGLE_BIT = 28;

  // Status-word layout
  localparam int STAT_STATE_LSB   = 29;
  localparam int STAT_EOP_BIT     = 28;
  localparam int STAT_OVERRUN_BIT = 27;
  localparam int STAT_ERROR_BIT   = 26;

  // Builds a default-width command word for host-side code.
  function automatic logic [NB_GPIO_DEF-1:0] makeCmd(
    input opcode_e                            op,
    input logic                               toggle,
    input logic [NB_DATA_DEF*N_PIX_DEF-1:0]   payload
  );
    logic [NB_GPIO_DEF-1:0] word;
    word = '0;
    word[NB_GPIO_DEF-1 -: NB_OPCODE_DEF] = op;
    word[CMD_TOGGLE_BIT]                 = toggle;
    word[NB_DATA_DEF*N_PIX_DEF-1:0]      = payload;
    return word;
  endfunction

endpackage

// File: rtl/gpio_toggle_detect.sv
// -----------------------------------------------------------------------------
// gpio_toggle_detect
// Registers the host command word once and turns a change of the toggle bit
// into a one-cycle command strobe with the registered opcode and payload.
//
// Ports
//   i_CLK         clock
//   i_reset       asynchronous active-high reset (toggle history cleared to 0)
//   i_gpioData    raw host command word
//   o_cmdStrobe   one-cycle strobe: a new command is present
//   o_cmdOpcode   registered opcode field
//   o_cmdPayload  registered payload field
// -----------------------------------------------------------------------------
module gpio_toggle_detect
  import gpio_cmd_decoder_pkg::*;
#(
  parameter int NB_GPIO    = NB_GPIO_DEF,
  parameter int NB_OPCODE  = NB_OPCODE_DEF,
  parameter int NB_PAYLOAD = NB_DATA_DEF * N_PIX_DEF
) (
  input  logic                  i_CLK,
  input  logic                  i_reset,
  input  logic [NB_GPIO-1:0]    i_gpioData,
  output logic                  o_cmdStrobe,
  output logic [NB_OPCODE-1:0]  o_cmdOpcode,
  output logic [NB_PAYLOAD-1:0] o_cmdPayload
);

  localparam int TGL_BIT = NB_GPIO - NB_OPCODE - 1;

  logic [NB_OPCODE-1:0]  opcode_p0;
  logic                  toggle_p0;
  logic [NB_PAYLOAD-1:0] payload_p0;
  logic                  toggleHist;

  // Bits between the toggle and the payload carry nothing.
  logic unusedReserved;
  assign unusedReserved = ^i_gpioData[TGL_BIT-1:NB_PAYLOAD];

  // ---- stage p0: input register and toggle history ----
  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      opcode_p0  <= '0;
      toggle_p0  <= 1'b0;
      toggleHist <= 1'b0;
    end else begin
      opcode_p0  <= i_gpioData[NB_GPIO-1 -: NB_OPCODE];
      toggle_p0  <= i_gpioData[TGL_BIT];
      toggleHist <= toggle_p0;
    end
  end

  // Payload is qualified by the strobe, so it needs no reset.
  always_ff @(posedge i_CLK) begin
    payload_p0 <= i_gpioData[NB_PAYLOAD-1:0];
  end

  // High for exactly one cycle per toggle edge, whichever direction.
  assign o_cmdStrobe  = toggle_p0 ^ toggleHist;
  assign o_cmdOpcode  = opcode_p0;
  assign o_cmdPayload = payload_p0;

endmodule

// File: rtl/gpio_cmd_decoder.sv
// -----------------------------------------------------------------------------
// gpio_cmd_decoder
// Decodes host commands written through a GPIO word into control levels and
// pulses for the image address FSM, feeds pixel words to the line memories,
// and builds a status word the host reads back.
//
// Ports
//   i_CLK          clock
//   i_reset        asynchronous active-high reset
//   i_gpioData     host command word: opcode, toggle strobe, payload
//   i_EoP          end-of-process flag from the address FSM
//   i_changeBlock  block-complete flag from the address FSM
//   i_result       convolver output word
//   o_load         load-mode level
//   o_SoP          start-of-process level
//   o_valid        one-cycle data-valid pulse (never on consecutive cycles)
//   o_softReset    one-cycle datapath reset pulse
//   o_imgLength    image-length register
//   o_pixels       pixel word to the line memories
//   o_gpioStatus   {state, EoP, overrun, error, 2'b0, last result}
// -----------------------------------------------------------------------------
module gpio_cmd_decoder
  import gpio_cmd_decoder_pkg::*;
#(
  parameter int NB_GPIO   = NB_GPIO_DEF,
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int N_PIX     = N_PIX_DEF,
  parameter int NB_IMAGE  = NB_IMAGE_DEF,
  parameter int NB_OPCODE = NB_OPCODE_DEF
) (
  input  logic                     i_CLK,
  input  logic                     i_reset,
  input  logic [NB_GPIO-1:0]       i_gpioData,
  input  logic                     i_EoP,
  input  logic                     i_changeBlock,
  input  logic [NB_DATA*N_PIX-1:0] i_result,
  output logic                     o_load,
  output logic                     o_SoP,
  output logic                     o_valid,
  output logic                     o_softReset,
  output logic [NB_IMAGE-1:0]      o_imgLength,
  output logic [NB_DATA*N_PIX-1:0] o_pixels,
  output logic [NB_GPIO-1:0]       o_gpioStatus
);

  localparam int NB_PIXW = NB_DATA * N_PIX;

  logic                 cmdStrobe;
  logic [NB_OPCODE-1:0] cmdOpcode;
  logic [NB_PIXW-1:0]   cmdPayload;
  opcode_e              cmdOp;

  state_e               state;
  logic                 pending;
  logic                 pendingIsData;
  logic [NB_PIXW-1:0]   pendingPix;
  logic                 validIsRead;
  logic                 rdVld_p1;
  logic                 rdVld_p2;
  logic [NB_PIXW-1:0]   resultReg;
  logic                 overrun;
  logic                 errorFlag;

  logic                 softRstCmd;
  logic                 cmdIllegal;
  logic                 pulseReq;
  logic                 reqIsData;

  gpio_toggle_detect #(
    .NB_GPIO    (NB_GPIO),
    .NB_OPCODE  (NB_OPCODE),
    .NB_PAYLOAD (NB_PIXW)
  ) u_toggleDetect (
    .i_CLK        (i_CLK),
    .i_reset      (i_reset),
    .i_gpioData   (i_gpioData),
    .o_cmdStrobe  (cmdStrobe),
    .o_cmdOpcode  (cmdOpcode),
    .o_cmdPayload (cmdPayload)
  );

  assign cmdOp      = opcode_e'(cmdOpcode);
  assign softRstCmd = cmdStrobe && (cmdOp == OP_SOFT_RST);

  // Which commands are not allowed in the current state. ERROR ignores
  // everything except SOFT_RST, which is handled ahead of this check.
  always_comb begin
    cmdIllegal = 1'b0;
    if (cmdStrobe) begin
      case (state)
        ST_IDLE: cmdIllegal = (cmdOp == OP_DATA) || (cmdOp == OP_READ_NEXT) ||
                              ((cmdOp == OP_READ_START) && !i_EoP);
        ST_LOAD: cmdIllegal = !((cmdOp == OP_NOP) || (cmdOp == OP_DATA));
        ST_PROC: cmdIllegal = (cmdOp != OP_NOP);
        ST_READ: cmdIllegal = !((cmdOp == OP_NOP) || (cmdOp == OP_READ_NEXT));
        default: cmdIllegal = 1'b0;
      endcase
    end
  end

  // Commands that ask for an o_valid pulse: DATA in LOAD, READ_NEXT in READ.
  always_comb begin
    pulseReq  = 1'b0;
    reqIsData = 1'b0;
    if (cmdStrobe && !softRstCmd) begin
      if ((state == ST_LOAD) && (cmdOp == OP_DATA)) begin
        pulseReq  = 1'b1;
        reqIsData = 1'b1;
      end else if ((state == ST_READ) && (cmdOp == OP_READ_NEXT)) begin
        pulseReq = 1'b1;
      end
    end
  end

  // ---- stage p1: FSM, valid pulse queue, result capture pipeline ----
  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      o_load        <= 1'b0;
      o_SoP         <= 1'b0;
      o_valid       <= 1'b0;
      o_softReset   <= 1'b0;
      o_imgLength   <= '0;
      o_pixels      <= '0;
      pending       <= 1'b0;
      pendingIsData <= 1'b0;
      validIsRead   <= 1'b0;
      rdVld_p1      <= 1'b0;
      rdVld_p2      <= 1'b0;
      resultReg     <= '0;
      overrun       <= 1'b0;
      errorFlag     <= 1'b0;
    end else if (softRstCmd) begin
      // Wins over everything else, including i_changeBlock; keeps o_imgLength.
      state         <= ST_IDLE;
      o_load        <= 1'b0;
      o_SoP         <= 1'b0;
      o_valid       <= 1'b0;
      o_softReset   <= 1'b1;
      o_pixels      <= '0;
      pending       <= 1'b0;
      pendingIsData <= 1'b0;
      validIsRead   <= 1'b0;
      rdVld_p1      <= 1'b0;
      rdVld_p2      <= 1'b0;
      resultReg     <= '0;
      overrun       <= 1'b0;
      errorFlag     <= 1'b0;
    end else begin
      o_softReset <= 1'b0;

      // One-deep queue: a request landing on a live pulse waits one slot;
      // a request while the slot is taken is dropped and flagged.
      if (o_valid) begin
        o_valid <= 1'b0;
        if (pulseReq) begin
          if (pending) begin
            overrun <= 1'b1;
          end else begin
            pending       <= 1'b1;
            pendingIsData <= reqIsData;
          end
        end
      end else if (pending) begin
        o_valid     <= 1'b1;
        validIsRead <= !pendingIsData;
        if (pendingIsData) o_pixels <= pendingPix;
        pending <= pulseReq;
        if (pulseReq) pendingIsData <= reqIsData;
      end else if (pulseReq) begin
        o_valid     <= 1'b1;
        validIsRead <= !reqIsData;
        if (reqIsData) o_pixels <= cmdPayload;
      end

      // The convolver result trails a read pulse by two cycles.
      rdVld_p1 <= o_valid && validIsRead;
      rdVld_p2 <= rdVld_p1;
      if (rdVld_p2) resultReg <= i_result;

      if (cmdIllegal) begin
        state     <= ST_ERROR;
        errorFlag <= 1'b1;
        o_load    <= 1'b0;
        o_SoP     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmdStrobe) begin
              case (cmdOp)
                OP_SET_LEN:    o_imgLength <= cmdPayload[NB_IMAGE-1:0];
                OP_LOAD_START: begin
                  state  <= ST_LOAD;
                  o_load <= 1'b1;
                end
                OP_START_PROC: begin
                  state <= ST_PROC;
                  o_SoP <= 1'b1;
                end
                // i_EoP is known to be high here, otherwise it was illegal.
                OP_READ_START: state <= ST_READ;
                default: ;
              endcase
            end
          end
          ST_LOAD: begin
            if (i_changeBlock) begin
              state  <= ST_IDLE;
              o_load <= 1'b0;
            end
          end
          ST_PROC: begin
            if (i_EoP) begin
              state <= ST_IDLE;
              o_SoP <= 1'b0;
            end
          end
          ST_READ: begin
            if (i_changeBlock) state <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Holds the payload of a queued DATA command until its slot comes up.
  always_ff @(posedge i_CLK) begin
    if (pulseReq && (o_valid ? !pending : pending)) pendingPix <= cmdPayload;
  end

  always_comb begin
    o_gpioStatus                         = '0;
    o_gpioStatus[STAT_STATE_LSB +: 3]    = state;
    o_gpioStatus[STAT_EOP_BIT]           = i_EoP;
    o_gpioStatus[STAT_OVERRUN_BIT]       = overrun;
    o_gpioStatus[STAT_ERROR_BIT]         = errorFlag;
    o_gpioStatus[NB_PIXW-1:0]            = resultReg;
  end

endmodule

// File: tb/tb_gpio_cmd_decoder.sv
module tb_gpio_cmd_decoder;
  import gpio_cmd_decoder_pkg::*;

  logic        i_CLK;
  logic        i_reset;
  logic [31:0] i_gpioData;
  logic        i_EoP;
  logic        i_changeBlock;
  logic [23:0] i_result;
  logic        o_load;
  logic        o_SoP;
  logic        o_valid;
  logic        o_softReset;
  logic [9:0]  o_imgLength;
  logic [23:0] o_pixels;
  logic [31:0] o_gpioStatus;

  int   nChecks = 0;
  int   nFails  = 0;
  logic toggleBit;
  logic sopHeld;

  gpio_cmd_decoder dut (
    .i_CLK         (i_CLK),
    .i_reset       (i_reset),
    .i_gpioData    (i_gpioData),
    .i_EoP         (i_EoP),
    .i_changeBlock (i_changeBlock),
    .i_result      (i_result),
    .o_load        (o_load),
    .o_SoP         (o_SoP),
    .o_valid       (o_valid),
    .o_softReset   (o_softReset),
    .o_imgLength   (o_imgLength),
    .o_pixels      (o_pixels),
    .o_gpioStatus  (o_gpioStatus)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge i_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sendCmd(input opcode_e op, input logic [23:0] payload);
    toggleBit  = ~toggleBit;
    i_gpioData = {op, toggleBit, 4'b0000, payload};
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_load"},   {31'd0, o_load},      32'd0);
    chk({tag, "_sop"},    {31'd0, o_SoP},       32'd0);
    chk({tag, "_valid"},  {31'd0, o_valid},     32'd0);
    chk({tag, "_srst"},   {31'd0, o_softReset}, 32'd0);
    chk({tag, "_len"},    {22'd0, o_imgLength}, 32'd0);
    chk({tag, "_pix"},    {8'd0, o_pixels},     32'd0);
    chk({tag, "_status"}, o_gpioStatus,         32'd0);
  endtask

  initial begin
    logic [23:0] words [3];
    words[0] = 24'h0A0B0C;
    words[1] = 24'h010203;
    words[2] = 24'hFFFFFF;

    i_reset       = 1'b1;
    i_gpioData    = 32'd0;
    i_EoP         = 1'b0;
    i_changeBlock = 1'b0;
    i_result      = 24'd0;
    toggleBit     = 1'b0;
    tick(2);
    chkAllZero("rst");
    i_reset = 1'b0;
    tick(1);
    chkAllZero("post_rst");

    // SET_LEN 10
    sendCmd(OP_SET_LEN, 24'd10);
    tick(1);
    chk("setlen_early", {22'd0, o_imgLength}, 32'd0);
    tick(1);
    chk("setlen", {22'd0, o_imgLength}, 32'd10);
    chk("setlen_state", {29'd0, o_gpioStatus[31:29]}, 32'd0);

    // LOAD_START and three DATA words
    sendCmd(OP_LOAD_START, 24'd0);
    tick(2);
    chk("load_lvl", {31'd0, o_load}, 32'd1);
    chk("load_state", {29'd0, o_gpioStatus[31:29]}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      sendCmd(OP_DATA, words[i]);
      tick(1);
      chk("data_pre_valid", {31'd0, o_valid}, 32'd0);
      tick(1);
      chk("data_valid", {31'd0, o_valid}, 32'd1);
      chk("data_pix", {8'd0, o_pixels}, {8'd0, words[i]});
      chk("data_load", {31'd0, o_load}, 32'd1);
      tick(1);
      chk("data_valid_end", {31'd0, o_valid}, 32'd0);
    end

    // Back-to-back DATA: one queued, one dropped with overrun
    sendCmd(OP_DATA, 24'h111111);
    tick(1);
    sendCmd(OP_DATA, 24'h222222);
    tick(1);
    chk("burst_v1", {31'd0, o_valid}, 32'd1);
    chk("burst_p1", {8'd0, o_pixels}, 32'h111111);
    sendCmd(OP_DATA, 24'h333333);
    tick(1);
    chk("burst_gap1", {31'd0, o_valid}, 32'd0);
    sendCmd(OP_DATA, 24'h444444);
    tick(1);
    chk("burst_v2", {31'd0, o_valid}, 32'd1);
    chk("burst_p2", {8'd0, o_pixels}, 32'h222222);
    tick(1);
    chk("burst_gap2", {31'd0, o_valid}, 32'd0);
    chk("overrun", {31'd0, o_gpioStatus[27]}, 32'd1);
    tick(1);
    chk("burst_v3", {31'd0, o_valid}, 32'd1);
    chk("burst_p3", {8'd0, o_pixels}, 32'h333333);
    tick(1);
    chk("burst_gap3", {31'd0, o_valid}, 32'd0);
    tick(1);
    chk("burst_drop", {31'd0, o_valid}, 32'd0);
    chk("burst_drop_pix", {8'd0, o_pixels}, 32'h333333);

    // Block complete leaves LOAD
    i_changeBlock = 1'b1;
    tick(1);
    i_changeBlock = 1'b0;
    chk("cb_load", {31'd0, o_load}, 32'd0);
    chk("cb_state", {29'd0, o_gpioStatus[31:29]}, 32'd0);

    // START_PROC, i_EoP 40 cycles after the command
    sendCmd(OP_START_PROC, 24'd0);
    tick(2);
    chk("proc_state", {29'd0, o_gpioStatus[31:29]}, 32'd2);
    sopHeld = 1'b1;
    for (int i = 0; i < 38; i++) begin
      sopHeld = sopHeld & o_SoP;
      tick(1);
    end
    sopHeld = sopHeld & o_SoP;
    chk("sop_held", {31'd0, sopHeld}, 32'd1);
    i_EoP = 1'b1;
    tick(1);
    chk("sop_drop", {31'd0, o_SoP}, 32'd0);
    chk("proc_end_state", {29'd0, o_gpioStatus[31:29]}, 32'd0);
    chk("status_eop", {31'd0, o_gpioStatus[28]}, 32'd1);

    // READ_START with i_EoP=1, then READ_NEXT
    sendCmd(OP_READ_START, 24'd0);
    tick(2);
    chk("read_state", {29'd0, o_gpioStatus[31:29]}, 32'd3);
    chk("read_load", {31'd0, o_load}, 32'd0);
    chk("read_sop", {31'd0, o_SoP}, 32'd0);
    i_result = 24'h123456;
    sendCmd(OP_READ_NEXT, 24'd0);
    tick(2);
    chk("read_valid", {31'd0, o_valid}, 32'd1);
    tick(1);
    chk("read_valid_end", {31'd0, o_valid}, 32'd0);
    chk("read_result_early", {8'd0, o_gpioStatus[23:0]}, 32'd0);
    tick(3);
    chk("read_result", {8'd0, o_gpioStatus[23:0]}, 32'h123456);
    i_changeBlock = 1'b1;
    tick(1);
    i_changeBlock = 1'b0;
    i_EoP         = 1'b0;
    chk("read_exit", {29'd0, o_gpioStatus[31:29]}, 32'd0);

    // DATA in IDLE is illegal
    sendCmd(OP_DATA, 24'hABCDEF);
    tick(2);
    chk("err_flag", {31'd0, o_gpioStatus[26]}, 32'd1);
    chk("err_state", {29'd0, o_gpioStatus[31:29]}, 32'd4);
    chk("err_no_valid", {31'd0, o_valid}, 32'd0);

    // SOFT_RST recovers
    sendCmd(OP_SOFT_RST, 24'd0);
    tick(1);
    chk("srst_early", {31'd0, o_softReset}, 32'd0);
    tick(1);
    chk("srst_pulse", {31'd0, o_softReset}, 32'd1);
    chk("srst_status", o_gpioStatus, 32'd0);
    chk("srst_len", {22'd0, o_imgLength}, 32'd10);
    chk("srst_pix", {8'd0, o_pixels}, 32'd0);
    tick(1);
    chk("srst_pulse_end", {31'd0, o_softReset}, 32'd0);

    // SET_LEN 0 is taken as written
    sendCmd(OP_SET_LEN, 24'd0);
    tick(2);
    chk("setlen_zero", {22'd0, o_imgLength}, 32'd0);
    sendCmd(OP_SET_LEN, 24'd7);
    tick(2);
    chk("setlen_seven", {22'd0, o_imgLength}, 32'd7);

    // Reset asserted mid-PROC
    sendCmd(OP_START_PROC, 24'd0);
    tick(2);
    chk("proc2_sop", {31'd0, o_SoP}, 32'd1);
    #3;
    i_reset    = 1'b1;
    i_gpioData = 32'd0;
    toggleBit  = 1'b0;
    #1;
    chk("rst_async_sop", {31'd0, o_SoP}, 32'd0);
    chk("rst_async_len", {22'd0, o_imgLength}, 32'd0);
    tick(2);
    i_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chkAllZero("after_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
